// File: rtl/mem_pkg.sv
// Shared definitions for the memory port arbiter: sizes, arbiter states, requester ids.
package mem_pkg;

    localparam int unsigned MEM_AW    = 32;
    localparam int unsigned MEM_DW    = 32;
    localparam int unsigned MEM_WORDS = 1024;
    localparam int unsigned MEM_IW    = $clog2(MEM_WORDS);

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_e;

    // Word index of a byte address.
    function automatic logic [MEM_IW-1:0] word_idx(input logic [MEM_AW-1:0] addr);
        return addr[MEM_IW+1:2];
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-requester (IF / D) arbiter for a single-port async-read memory with 1-cycle responses.
// Build option MEM_ARB_RR_EN: round-robin contention instead of D-priority with IF starvation guard.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned AW           = MEM_AW,
    parameter int unsigned DW           = MEM_DW,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic          d_lock,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_e    r_state;
    logic          r_if_rvalid;
    logic [DW-1:0] r_if_rdata;
    logic          r_d_rvalid;
    logic [DW-1:0] r_d_rdata;
    logic          w_both;
    logic          w_if_gnt;
    logic          w_d_gnt;

`ifdef MEM_ARB_RR_EN
    req_id_e       r_last_gnt;
`else
    logic [3:0]    r_starve_cnt;
`endif

    always_comb begin
        w_both   = if_req & d_req;
        w_if_gnt = 1'b0;
        w_d_gnt  = 1'b0;
        if (rst_n) begin
            if (r_state == ARB_LOCKED) begin
                w_d_gnt = d_req;
            end else if (w_both) begin
`ifdef MEM_ARB_RR_EN
                w_d_gnt  = (r_last_gnt == REQ_IF);
`else
                w_d_gnt  = (r_starve_cnt != 4'(STARVE_LIMIT));
`endif
                w_if_gnt = ~w_d_gnt;
            end else begin
                w_d_gnt  = d_req;
                w_if_gnt = if_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ARB_IDLE;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= '0;
`ifdef MEM_ARB_RR_EN
            r_last_gnt  <= REQ_IF;
`else
            r_starve_cnt <= '0;
`endif
        end else begin
            r_if_rvalid <= w_if_gnt;
            r_d_rvalid  <= w_d_gnt;
            if (w_if_gnt) begin
                r_if_rdata <= mem_rdata;
            end
            if (w_d_gnt) begin
                r_d_rdata <= d_we ? '0 : mem_rdata;
            end

            case (r_state)
                ARB_IDLE:   if (w_d_gnt && d_lock) r_state <= ARB_LOCKED;
                ARB_LOCKED: if (!d_lock) r_state <= ARB_IDLE;
                default:    r_state <= ARB_IDLE;
            endcase

`ifdef MEM_ARB_RR_EN
            // Only contested IDLE cycles move the round-robin pointer.
            if (r_state == ARB_IDLE && w_both) begin
                r_last_gnt <= w_d_gnt ? REQ_D : REQ_IF;
            end
`else
            if (w_if_gnt) begin
                r_starve_cnt <= '0;
            end else if (if_req && r_starve_cnt != 4'(STARVE_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
`endif
        end
    end

    assign if_gnt    = w_if_gnt;
    assign d_gnt     = w_d_gnt;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;
    assign mem_we    = w_d_gnt & d_we;
    assign mem_addr  = w_d_gnt ? d_addr : (w_if_gnt ? if_addr : '0);
    assign mem_wdata = w_d_gnt ? d_wdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter; expected grant patterns follow MEM_ARB_RR_EN.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_lock, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [MEM_WORDS];
    logic [31:0] if_q[$];
    logic [31:0] d_q[$];
    logic [31:0] if_exp, d_exp;
    logic [9:0]  pat_if;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW(32), .DW(32), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory model: async read, write on the rising edge.
    assign mem_rdata = mem[word_idx(mem_addr)];
    always @(posedge clk) begin
        if (mem_we === 1'b1) mem[word_idx(mem_addr)] = mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic exp_gnt(input string nm, input logic ig, input logic dg);
        chk({nm, ".if_gnt"}, {31'd0, if_gnt}, {31'd0, ig});
        chk({nm, ".d_gnt"}, {31'd0, d_gnt}, {31'd0, dg});
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                         input logic dl, input logic [31:0] da, input logic [31:0] dw);
        if_req = ir; if_addr = ia;
        d_req = dr; d_we = dwe; d_lock = dl; d_addr = da; d_wdata = dw;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every response pulse pops the oldest expected value.
    always @(negedge clk) begin
        if (if_rvalid === 1'b1) begin
            if (if_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL if_rvalid_unexpected: got rvalid=1 expected 0");
            end else begin
                if_exp = if_q.pop_front();
                chk("if_rdata", if_rdata, if_exp);
            end
        end
        if (d_rvalid === 1'b1) begin
            if (d_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL d_rvalid_unexpected: got rvalid=1 expected 0");
            end else begin
                d_exp = d_q.pop_front();
                chk("d_rdata", d_rdata, d_exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = 32'h0;
        mem[0] = 32'h1111_0000;
        mem[2] = 32'h2222_0002;
        mem[4] = 32'hCAFE_F00D;
`ifdef MEM_ARB_RR_EN
        pat_if = 10'b10_1010_1010;
`else
        pat_if = 10'b10_0001_0000;
`endif

        // Reset with both requesting and a write pending.
        rst_n = 1'b0;
        drive(1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 32'h0, 32'hDEAD);
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_gnt("reset", 1'b0, 1'b0);
        chk("reset.mem_we", {31'd0, mem_we}, 32'd0);
        chk("reset.mem_addr", mem_addr, 32'd0);
        chk("reset.if_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("reset.d_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("reset.if_rdata", if_rdata, 32'd0);
        chk("reset.d_rdata", d_rdata, 32'd0);

        next_cycle();
        rst_n = 1'b1;
        drive(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        exp_gnt("release", 1'b0, 1'b1);
        d_q.push_back(32'h1111_0000);

        // Solo IF read of word 4.
        next_cycle();
        drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        exp_gnt("solo_if", 1'b1, 1'b0);
        chk("solo_if.mem_addr", mem_addr, 32'h10);
        if_q.push_back(32'hCAFE_F00D);

        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        exp_gnt("idle", 1'b0, 1'b0);

        // Contention from a clean reset state.
        next_cycle();
        rst_n = 1'b1;
        drive(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp_gnt($sformatf("contend%0d", i), pat_if[i], ~pat_if[i]);
            if (pat_if[i]) if_q.push_back(32'hCAFE_F00D);
            else d_q.push_back(32'h2222_0002);
            next_cycle();
        end

        // Locked write then locked read; IF must wait until lock drops.
        drive(1'b1, 32'h10, 1'b1, 1'b1, 1'b1, 32'h20, 32'h5);
        @(negedge clk);
        exp_gnt("lock_wr", 1'b0, 1'b1);
        chk("lock_wr.mem_we", {31'd0, mem_we}, 32'd1);
        d_q.push_back(32'h0);

        next_cycle();
        drive(1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 32'h20, 32'h0);
        @(negedge clk);
        exp_gnt("lock_rd", 1'b0, 1'b1);
        d_q.push_back(32'h5);

        next_cycle();
        drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 32'h20, 32'h0);
        @(negedge clk);
        exp_gnt("lock_hold", 1'b0, 1'b0);

        next_cycle();
        drive(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        exp_gnt("lock_last", 1'b0, 1'b1);
        d_q.push_back(32'h5);

        next_cycle();
        drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        exp_gnt("unlocked", 1'b1, 1'b0);
        if_q.push_back(32'hCAFE_F00D);

        // Back-to-back write then read of the same word.
        next_cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h40, 32'hA);
        @(negedge clk);
        exp_gnt("wr40", 1'b0, 1'b1);
        chk("wr40.mem_we", {31'd0, mem_we}, 32'd1);
        chk("wr40.mem_wdata", mem_wdata, 32'hA);
        d_q.push_back(32'h0);

        next_cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        exp_gnt("rd40", 1'b0, 1'b1);
        chk("rd40.mem_we", {31'd0, mem_we}, 32'd0);
        d_q.push_back(32'hA);

        // Reset while locked: lock released, no write during the reset cycle.
        next_cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h60, 32'h7);
        @(negedge clk);
        exp_gnt("lock_wr60", 1'b0, 1'b1);
        d_q.push_back(32'h0);

        next_cycle();
        rst_n = 1'b0;
        drive(1'b1, 32'h60, 1'b1, 1'b1, 1'b1, 32'h60, 32'h99);
        @(negedge clk);
        exp_gnt("mid_reset", 1'b0, 1'b0);
        chk("mid_reset.mem_we", {31'd0, mem_we}, 32'd0);

        next_cycle();
        rst_n = 1'b1;
        drive(1'b1, 32'h60, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        exp_gnt("post_reset", 1'b1, 1'b0);
        if_q.push_back(32'h7);

        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        exp_gnt("drain", 1'b0, 1'b0);
        next_cycle();
        @(negedge clk);
        #1;
        chk("if_q_drained", if_q.size(), 32'd0);
        chk("d_q_drained", d_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
